fir_controller_param: RTL and testbench

Parametrised successor to the fixed 4-tap FIR controller. It sequences an external register-file/ALU datapath to perform coefficient load, sample shift and signed MAC for NUM_TAPS taps. A per-tap sign mask replaces the hard-wired +/- pattern. It adds an overflow error exit and supports coefficient reload from both IDLE and the error state.

---
 rtl/fir_controller_param.sv | 184 ++++++++++++++++++
 tb/tb_fir_controller_param.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_controller_param.sv
// Sequencer for an external register-file/ALU datapath running an N-tap
// signed FIR: coefficient load, sample shift and MAC with a per-tap sign mask.
module fir_controller_param #(
  parameter int                  NUM_TAPS  = 4,
  parameter int                  ADDR_W    = 4,
  parameter logic [NUM_TAPS-1:0] SIGN_MASK = 4'b1010
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              dr,
  input  logic              lc,
  input  logic              overflow,
  output logic              cnt_up,
  output logic              clear,
  output logic              modwait,
  output logic [2:0]        op,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest,
  output logic              err
);

  localparam int KW = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
  localparam int MW = 1 << KW;

  localparam logic [MW-1:0]     MASK   = MW'(SIGN_MASK);
  localparam logic [KW-1:0]     K_LAST = KW'(NUM_TAPS - 1);
  localparam logic [KW-1:0]     J_LAST = KW'(1);
  localparam logic [ADDR_W-1:0] R0     = '0;
  localparam logic [ADDR_W-1:0] F_BASE = ADDR_W'(NUM_TAPS + 1);
  localparam logic [ADDR_W-1:0] TMP    = ADDR_W'(2 * NUM_TAPS + 1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_COPY  = 3'd1;
  localparam logic [2:0] OP_LOAD1 = 3'd2;
  localparam logic [2:0] OP_LOAD2 = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE,
    S_EIDLE,
    S_LOAD_C,
    S_WAIT_C,
    S_CHECK_DR,
    S_CLR_ACC,
    S_SHIFT,
    S_LOAD_S,
    S_MUL,
    S_ACC
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   j_q, j_d;
  logic            ovf_exit;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
    end
  end

  // Overflow only matters while the accumulator is being built.
  assign ovf_exit = overflow &&
    (state_q == S_CLR_ACC || state_q == S_MUL || state_q == S_ACC);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    unique case (state_q)
      S_IDLE, S_EIDLE: begin
        if (dr) begin
          state_d = S_CHECK_DR;
        end else if (lc) begin
          state_d = S_LOAD_C;
          k_d     = '0;
        end
      end
      S_LOAD_C: begin
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_C;
          k_d     = k_q + 1'b1;
        end
      end
      S_WAIT_C: begin
        if (lc) state_d = S_LOAD_C;
      end
      S_CHECK_DR: begin
        state_d = dr ? S_CLR_ACC : S_EIDLE;
      end
      S_CLR_ACC: begin
        state_d = S_SHIFT;
        j_d     = K_LAST;
      end
      S_SHIFT: begin
        if (j_q == J_LAST) state_d = S_LOAD_S;
        else               j_d     = j_q - 1'b1;
      end
      S_LOAD_S: begin
        state_d = S_MUL;
        k_d     = '0;
      end
      S_MUL: begin
        state_d = S_ACC;
      end
      S_ACC: begin
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MUL;
          k_d     = k_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ovf_exit) state_d = S_EIDLE;
  end

  always_comb begin
    cnt_up  = 1'b0;
    clear   = 1'b0;
    modwait = 1'b1;
    op      = OP_NOP;
    src1    = '0;
    src2    = '0;
    dest    = '0;
    err     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        modwait = 1'b0;
      end
      S_EIDLE: begin
        modwait = 1'b0;
        err     = 1'b1;
      end
      S_LOAD_C: begin
        op    = OP_LOAD2;
        dest  = F_BASE + ADDR_W'(k_q);
        clear = (k_q == '0);
      end
      S_CLR_ACC: begin
        op   = OP_SUB;
        dest = R0;
        src1 = R0;
        src2 = R0;
      end
      S_SHIFT: begin
        op   = OP_COPY;
        dest = ADDR_W'(j_q) + 1'b1;
        src1 = ADDR_W'(j_q);
      end
      S_LOAD_S: begin
        op     = OP_LOAD1;
        dest   = ADDR_W'(1);
        cnt_up = 1'b1;
      end
      S_MUL: begin
        op   = OP_MUL;
        dest = TMP;
        src1 = ADDR_W'(k_q) + 1'b1;
        src2 = F_BASE + ADDR_W'(k_q);
      end
      S_ACC: begin
        op   = MASK[k_q] ? OP_SUB : OP_ADD;
        dest = R0;
        src1 = R0;
        src2 = TMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_controller_param.sv
// Randomised scoreboard bench for fir_controller_param: a 4-tap and a 6-tap
// instance, expected per-cycle outputs built from operation lists.
module tb_fir_controller_param;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] d;
    logic       cu;
    logic       cl;
    logic       mw;
    logic       er;
  } out_t;

  typedef struct {
    out_t e;
    bit   elig;
    bit   acc;
  } step_t;

  logic clk = 1'b0;
  logic n_rst, dr, lc, ovf;
  logic sel6;

  logic       cu4, cl4, mw4, er4, cu6, cl6, mw6, er6;
  logic [2:0] op4, op6;
  logic [3:0] a4, b4, d4, a6, b6, d6;

  int checks = 0;
  int failures = 0;

  out_t q[$];
  out_t got;
  int   cur_n;
  logic [7:0] cur_mask;
  bit   in_err;

  always #5 clk = ~clk;

  fir_controller_param #(
    .NUM_TAPS(4), .ADDR_W(4), .SIGN_MASK(4'b1010)
  ) u_dut4 (
    .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(ovf),
    .cnt_up(cu4), .clear(cl4), .modwait(mw4), .op(op4),
    .src1(a4), .src2(b4), .dest(d4), .err(er4)
  );

  fir_controller_param #(
    .NUM_TAPS(6), .ADDR_W(4), .SIGN_MASK(6'b000000)
  ) u_dut6 (
    .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(ovf),
    .cnt_up(cu6), .clear(cl6), .modwait(mw6), .op(op6),
    .src1(a6), .src2(b6), .dest(d6), .err(er6)
  );

  always_comb begin
    if (sel6) got = {op6, a6, b6, d6, cu6, cl6, mw6, er6};
    else      got = {op4, a4, b4, d4, cu4, cl4, mw4, er4};
  end

  function automatic out_t mk(int o, int s1, int s2, int d,
                              bit cu, bit cl, bit mw, bit er);
    out_t r;
    r.op = 3'(o);
    r.s1 = 4'(s1);
    r.s2 = 4'(s2);
    r.d  = 4'(d);
    r.cu = cu;
    r.cl = cl;
    r.mw = mw;
    r.er = er;
    return r;
  endfunction

  function automatic out_t rest();
    return mk(0, 0, 0, 0, 0, 0, 0, in_err);
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string nm, input out_t g, input out_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s t=%0t got op=%0d s1=%0d s2=%0d d=%0d cu=%0b cl=%0b mw=%0b err=%0b exp op=%0d s1=%0d s2=%0d d=%0d cu=%0b cl=%0b mw=%0b err=%0b",
               nm, $time, g.op, g.s1, g.s2, g.d, g.cu, g.cl, g.mw, g.er,
               e.op, e.s1, e.s2, e.d, e.cu, e.cl, e.mw, e.er);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) chk("cycle", got, q.pop_front());
  end

  task automatic step(input out_t e, input logic d, input logic l,
                      input logic o);
    @(posedge clk);
    #1;
    dr  = d;
    lc  = l;
    ovf = o;
    q.push_back(e);
  endtask

  task automatic ep_idle(input int cyc);
    repeat (cyc) step(rest(), 1'b0, 1'b0, rb());
  endtask

  task automatic ep_load(input int gapmax);
    int n = cur_n;
    step(rest(), 1'b0, 1'b1, rb());
    for (int k = 0; k < n; k++) begin
      step(mk(3, 0, 0, n + 1 + k, 0, k == 0, 1, 0), rb(), rb(), rb());
      if (k < n - 1) begin
        repeat ($urandom_range(0, gapmax))
          step(mk(0, 0, 0, 0, 0, 0, 1, 0), rb(), 1'b0, rb());
        step(mk(0, 0, 0, 0, 0, 0, 1, 0), rb(), 1'b1, rb());
      end
    end
    in_err = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    dr = 1'b0;
    lc = 1'b0;
    ovf = 1'b0;
    #1;
    chk("async_rst_now", got, mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #2;
    chk("async_rst_held", got, mk(0, 0, 0, 0, 0, 0, 0, 0));
    n_rst = 1'b1;
    in_err = 1'b0;
  endtask

  // One filter pass as a list of datapath operations, then played out.
  task automatic ep_sample(input bit spur, input int ovf_at,
                           input int rst_at);
    int n = cur_n;
    step_t ops[$];
    step_t s;
    logic o;
    step(rest(), 1'b1, rb(), rb());
    if (spur) begin
      step(mk(0, 0, 0, 0, 0, 0, 1, 0), 1'b0, rb(), rb());
      in_err = 1'b1;
      return;
    end
    step(mk(0, 0, 0, 0, 0, 0, 1, 0), 1'b1, rb(), rb());
    s.e = mk(5, 0, 0, 0, 0, 0, 1, 0); s.elig = 1; s.acc = 0;
    ops.push_back(s);
    for (int j = n - 1; j >= 1; j--) begin
      s.e = mk(1, j, 0, j + 1, 0, 0, 1, 0); s.elig = 0; s.acc = 0;
      ops.push_back(s);
    end
    s.e = mk(2, 0, 0, 1, 1, 0, 1, 0); s.elig = 0; s.acc = 0;
    ops.push_back(s);
    for (int k = 0; k < n; k++) begin
      s.e = mk(6, k + 1, n + 1 + k, 2 * n + 1, 0, 0, 1, 0);
      s.elig = 1; s.acc = 0;
      ops.push_back(s);
      s.e = mk(cur_mask[k] ? 5 : 4, 0, 2 * n + 1, 0, 0, 0, 1, 0);
      s.elig = 1; s.acc = 1;
      ops.push_back(s);
    end
    for (int i = 0; i < ops.size(); i++) begin
      o = (i == ovf_at) ? 1'b1 : (ops[i].elig ? 1'b0 : rb());
      step(ops[i].e, rb(), rb(), o);
      if (i == ovf_at && ops[i].elig) begin
        in_err = 1'b1;
        return;
      end
      if (i == rst_at && ops[i].acc) begin
        async_reset();
        return;
      end
    end
    in_err = 1'b0;
  endtask

  task automatic ep_random();
    int r = $urandom_range(0, 9);
    int n = cur_n;
    if (r <= 2) ep_load(3);
    else if (r <= 6) ep_sample(0, $urandom_range(0, 3 * n + 6), -1);
    else if (r == 7) ep_sample(1, -1, -1);
    else if (r == 8)
      ep_sample(0, -1, n + 2 + 2 * $urandom_range(0, n - 1));
    else ep_idle($urandom_range(1, 3));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel6 = 1'b0;
    cur_n = 4;
    cur_mask = 8'b0000_1010;
    in_err = 1'b0;
    n_rst = 1'b0;
    dr = 1'b0;
    lc = 1'b0;
    ovf = 1'b0;
    #2;
    chk("reset4", got, mk(0, 0, 0, 0, 0, 0, 0, 0));
    sel6 = 1'b1;
    #1;
    chk("reset6", got, mk(0, 0, 0, 0, 0, 0, 0, 0));
    sel6 = 1'b0;
    #9;
    n_rst = 1'b1;

    ep_load(0);
    ep_sample(0, -1, -1);
    ep_sample(1, -1, -1);
    ep_sample(0, -1, -1);
    ep_sample(0, cur_n + 3, -1);
    ep_idle(2);
    ep_load(0);
    ep_sample(0, -1, cur_n + 2);
    ep_sample(0, -1, -1);
    repeat (120) ep_random();

    @(negedge clk);
    #1;
    n_rst = 1'b0;
    dr = 1'b0;
    lc = 1'b0;
    ovf = 1'b0;
    sel6 = 1'b1;
    cur_n = 6;
    cur_mask = 8'b0000_0000;
    in_err = 1'b0;
    #1;
    chk("reset6_phase", got, mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #2;
    n_rst = 1'b1;

    ep_sample(0, -1, -1);
    ep_load(1);
    ep_sample(0, cur_n + 5, -1);
    ep_sample(0, -1, -1);
    repeat (50) ep_random();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
